// File: rtl/mips_cpu_div_pkg.sv
// Shared types and constants for the MIPS DIV/DIVU iterative divider.
package mips_cpu_div_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam logic [DEFAULT_WIDTH-1:0] DIV_ZERO_LO = '1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    SIGN,
    DONE
  } div_state_t;

endpackage

// File: rtl/mips_cpu_div_step.sv
// One combinational restoring-division step: conditional subtract and quotient shift-in.
module mips_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next,
  output logic             ge
);

  assign ge       = (rem >= d);
  assign rem_next = ge ? (rem - d) : rem;
  assign q_next   = {q[WIDTH-2:0], ge};

endmodule

// File: rtl/mips_cpu_divider.sv
// Iterative shift-subtract divider for DIV/DIVU: magnitudes in, signed-corrected HI/LO out.
// state | meaning
// IDLE  | waiting for start; results held
// ITER  | one restoring step per cycle, divisor shifting right
// SIGN  | apply quotient/remainder negation, write HI/LO
// DONE  | one-cycle done pulse, back to IDLE
module mips_cpu_divider
  import mips_cpu_div_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_ITER = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  input  logic [WIDTH-1:0] shiftb,
  input  logic             q_neg,
  input  logic             r_neg,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;

  div_state_t state, state_next;

  logic [WIDTH-1:0] rem, d, q, b_reg;
  logic [CW-1:0]    count;
  logic             q_neg_r, r_neg_r;
  logic [WIDTH-1:0] step_rem, step_q;
  logic             step_ge;
  logic             iter_last;

  mips_cpu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .d        (d),
    .q        (q),
    .rem_next (step_rem),
    .q_next   (step_q),
    .ge       (step_ge)
  );

  // The count cap keeps a malformed shiftb from looping forever.
  assign iter_last = (d == b_reg) || (count == CW'(MAX_ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (b_mag == '0)        state_next = DONE;
          else if (a_mag < b_mag) state_next = SIGN;
          else                    state_next = ITER;
        end
      end
      ITER:    if (iter_last) state_next = SIGN;
      SIGN:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == ITER) || (state == SIGN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      d        <= '0;
      q        <= '0;
      b_reg    <= '0;
      count    <= '0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem      <= a_mag;
            d        <= shiftb;
            b_reg    <= b_mag;
            q        <= '0;
            count    <= '0;
            q_neg_r  <= q_neg;
            r_neg_r  <= r_neg;
            div_zero <= (b_mag == '0);
            if (b_mag == '0) begin
              hi <= a_mag;
              lo <= {WIDTH{DIV_ZERO_LO[0]}};
            end
          end
        end
        ITER: begin
          if (step_ge) rem <= step_rem;
          q <= step_q;
          if (!iter_last) begin
            d     <= d >> 1;
            count <= count + CW'(1);
          end
        end
        SIGN: begin
          lo <= q_neg_r ? -q : q;
          hi <= r_neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_divider.sv
// Scoreboard bench for mips_cpu_divider: driver pushes model results, negedge monitor checks them.
module tb_mips_cpu_divider;
  import mips_cpu_div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_mag = '0, b_mag = '0, shiftb = '0;
  logic         q_neg = 1'b0, r_neg = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mips_cpu_divider #(.WIDTH(W), .MAX_ITER(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .shiftb   (shiftb),
    .q_neg    (q_neg),
    .r_neg    (r_neg),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    time          t0;
    bit           chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Largest k with b<<k <= a, computed in wide arithmetic.
  function automatic int align_shift(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned aa = 64'(a);
    longint unsigned bb = 64'(b);
    int k = 0;
    while (k < W - 1 && (bb << (k + 1)) <= aa) k++;
    return k;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic qn, input logic rn);
    exp_t e;
    logic [W-1:0] qq, rr;
    e.chk_data = 1'b1;
    e.t0 = 0;
    if (b == '0) begin
      e.dz = 1'b1; e.hi = a; e.lo = DIV_ZERO_LO; e.lat = 1;
    end else begin
      qq = a / b;
      rr = a % b;
      e.dz  = 1'b0;
      e.lo  = qn ? -qq : qq;
      e.hi  = rn ? -rr : rr;
      e.lat = (a < b) ? 2 : align_shift(a, b) + 3;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    int   n;
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        n = int'(($time - exp_q[0].t0 + 5) / 10);
        check("busy", 64'(busy), 64'(n >= 1 && n < exp_q[0].lat));
      end else begin
        n = 0;
        check("busy_idle", 64'(busy), 64'(0));
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("latency", 64'(n), 64'(e.lat));
          if (e.chk_data) begin
            check("lo", 64'(lo), 64'(e.lo));
            check("hi", 64'(hi), 64'(e.hi));
            check("div_zero", 64'(div_zero), 64'(e.dz));
          end
          done_cnt++;
        end
      end
    end
  end

  task automatic scramble();
    a_mag  = $urandom;
    b_mag  = $urandom | 32'd1;
    shiftb = $urandom;
    q_neg  = 1'($urandom);
    r_neg  = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] sb,
                        input logic qn, input logic rn,
                        input bit poke_busy, input bit poke_done, input bit chk_data);
    exp_t e;
    int   seen;
    bit   poked;
    @(negedge clk); #1;
    a_mag = a; b_mag = b; shiftb = sb; q_neg = qn; r_neg = rn; start = 1'b1;
    @(posedge clk);
    e = model(a, b, qn, rn);
    e.chk_data = chk_data;
    if (!chk_data) e.lat = W + 2;
    e.t0 = $time;
    exp_q.push_back(e);
    seen = done_cnt;
    #1;
    start = 1'b0;
    scramble();
    poked = 1'b0;
    for (int i = 0; i < 100 && done_cnt == seen; i++) begin
      @(negedge clk); #1;
      if (start) start = 1'b0;
      else if (poke_busy && !poked && busy) begin
        start = 1'b1;
        scramble();
        poked = 1'b1;
      end
    end
    if (done_cnt == seen) begin
      check("timeout", 64'(done_cnt), 64'(seen + 1));
      exp_q.delete();
    end else if (poke_done) begin
      start = 1'b1;
      scramble();
      @(negedge clk); #1;
    end
    start = 1'b0;
    if (chk_data) begin
      repeat (2) @(negedge clk);
      #1;
      check("hold_lo", 64'(lo), 64'(e.lo));
      check("hold_hi", 64'(hi), 64'(e.hi));
      check("hold_dz", 64'(div_zero), 64'(e.dz));
    end
  endtask

  initial begin
    logic [W-1:0] a, b, sb;
    exp_t e;
    int sel;

    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    @(negedge clk); #2;
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 32'd56, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_op(32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op(32'd3, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op(32'd10, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'd7, 32'd2, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Abort a 100/7 division mid-iteration with an asynchronous reset.
    @(negedge clk); #1;
    a_mag = 32'd100; b_mag = 32'd7; shiftb = 32'd56; q_neg = 1'b0; r_neg = 1'b0; start = 1'b1;
    @(posedge clk);
    e = model(32'd100, 32'd7, 1'b0, 1'b0);
    e.t0 = $time;
    exp_q.push_back(e);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_dz", 64'(div_zero), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    @(negedge clk); #2;
    rst_n = 1'b1;
    run_op(32'd50, 32'd5, 32'd40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel == 1) b = (a == '1) ? a : a + 32'd1 + 32'($urandom_range(0, 50));
      else               b = $urandom >> $urandom_range(0, 31);
      if (b == '0)    sb = '0;
      else if (a < b) sb = b;
      else            sb = b << align_shift(a, b);
      run_op(a, b, sb, 1'($urandom), 1'($urandom),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_divider.md
Name: mips_cpu_divider

Overview:
- Iterative shift-subtract divider core; sits directly downstream of the divisor-alignment stage in the MIPS CPU DIV/DIVU path.
- Takes dividend magnitude, divisor magnitude and the pre-aligned divisor (shiftb), and produces quotient (LO) and remainder (HI).
- Performs one restoring step per cycle, then applies sign correction.
- Start/busy/done handshake with the CPU control.

Parameters:
- WIDTH, 32, operand/result width.
- MAX_ITER, 32, hard cap on restoring iterations (safety bound).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low
- start  input  1  request a division; sampled in IDLE only
- a_mag  input  WIDTH  dividend magnitude
- b_mag  input  WIDTH  divisor magnitude
- shiftb  input  WIDTH  aligned divisor = b_mag<<k, k maximal with b_mag<<k <= a_mag; valid when start=1
- q_neg  input  1  negate quotient at end (signed DIV)
- r_neg  input  1  negate remainder at end (signed DIV)
- busy  output  1  high in ITER and SIGN
- done  output  1  one-cycle pulse in DONE
- div_zero  output  1  result flag, b_mag==0; held with results
- hi  output  WIDTH  remainder
- lo  output  WIDTH  quotient

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; internal rem/d/q/count=0. Reset mid-operation aborts immediately, with no partial results.
- IDLE:
  - start=0: stay.
  - start=1, b_mag==0: div_zero<=1, hi<=a_mag, lo<=all-ones, go to DONE. Sign step is skipped.
  - start=1, a_mag<b_mag: div_zero<=0, rem<=a_mag, q<=0, go to SIGN (zero iterations).
  - Otherwise: rem<=a_mag, d<=shiftb, q<=0, count<=0, go to ITER.
- ITER, one step per cycle:
  - If rem>=d: rem<=rem-d and q<={q[WIDTH-2:0],1}. Else q<={q[WIDTH-2:0],0}.
  - Terminate when d==b_mag (registered copy) or count==MAX_ITER-1; then go to SIGN. Otherwise d<=d>>1 and count++.
  - Comparisons and subtraction are unsigned, WIDTH bits; rem never underflows.
  - k+1 ITER cycles for shift amount k.
- SIGN (1 cycle):
  - lo<= q_neg ? -q : q; hi<= r_neg ? -rem : rem (two's complement, WIDTH bits).
  - q_neg/r_neg are registered at start.
  - Go to DONE.
- DONE (1 cycle): done=1, busy=0, go to IDLE. A start in DONE is ignored.
- hi/lo/div_zero hold until the next accepted start. A new start clears div_zero.
- start while busy: ignored, with no effect on the operation in progress.
- Latency: start sampled at edge 0; done high in cycle k+3 (k+1 ITER + SIGN + DONE). Zero-iteration case: done in cycle 2. Divide-by-zero: done in cycle 1.
- Operands a_mag/b_mag/shiftb may change after the start cycle; all are registered.
- A shiftb violating the precondition (not a shift of b_mag) is still bounded by MAX_ITER; the result is then undefined but the FSM must return to IDLE.

Decomposition:
- Shared package mips_cpu_div_pkg:
  - state enum div_state_t {IDLE, ITER, SIGN, DONE};
  - WIDTH default constant;
  - DIV_ZERO_LO constant (all-ones).
- One natural sub-module: mips_cpu_div_step. Combinational restoring step: rem, d, q in → rem_next, q_next, ge flag out. Instantiated once inside the FSM.
- Alignment itself stays in the existing alignment stage; this block does not re-align.

Test Plan:
- a=100, b=7, shiftb=56, q_neg=r_neg=0 → 4 ITER cycles; done at cycle 6; lo=14, hi=2, div_zero=0.
- a=0xFFFFFFFF, b=1, shiftb=0x80000000 → 32 ITER cycles; lo=0xFFFFFFFF, hi=0; done at cycle 34.
- Divide-by-zero: a=5, b=0, shiftb=0 → done at cycle 1, div_zero=1, hi=5, lo=0xFFFFFFFF, busy never high.
- Signed: a=7, b=2, shiftb=4, q_neg=1, r_neg=1 (−7/2) → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- a=3, b=9 (a<b), shiftb=9 → no ITER; done at cycle 2; lo=0, hi=3.
- rst_n pulsed low during ITER of 100/7 → all outputs 0 immediately, state IDLE. A new start (a=50, b=5, shiftb=40) then gives lo=10, hi=0. A start pulsed while busy is ignored (results unchanged).
